uart_rx: RTL and testbench
==========================

# uart_rx

UART receiver that rebuilds serial frames from the line using the 16x oversampling tick produced by the baud-rate generator. It detects the start bit, samples each data bit at mid-bit, checks the stop bit, and presents the received byte with a one-cycle done strobe. It sits between the board RX pin and the UART interface/FIFO logic that feeds the processor.

## Interface
- DBIT, 8, number of data bits per frame (LSB first)
- SB_TICK, 16, oversampling ticks for the stop bit (16 = 1 stop bit, 24 = 1.5, 32 = 2)
- i_clk  input  1  system clock, all logic on rising edge
- i_reset  input  1  asynchronous, active-low reset (asserted when 0)
- i_rx  input  1  serial line, idle high, asynchronous to i_clk
- i_s_tick  input  1  one-cycle-wide 16x oversampling tick from the baud generator
- o_dout  output  DBIT  last received data word
- o_rx_done_tick  output  1  one-cycle pulse when a frame completes
- o_frame_err  output  1  stop-bit sample of last frame was 0

## Operation
- i_rx passes through a 2-flop synchronizer, both flops reset to 1. All decisions use the synchronized value rx_s.
- FSM states: IDLE, START, DATA, STOP. There are two counters:
  - s_cnt counts ticks, 0..15 in START/DATA and 0..SB_TICK-1 in STOP.
  - n_cnt counts bits, 0..DBIT-1.
- IDLE: when rx_s == 0, go to START and clear s_cnt. No tick is needed for this transition.
- START: on each tick with s_cnt == 7 (mid start bit):
  - If rx_s == 0, go to DATA and clear s_cnt and n_cnt.
  - If rx_s == 1, treat it as a glitch and return to IDLE with no strobe.
  - Otherwise each tick increments s_cnt.
- DATA: on each tick with s_cnt == 15:
  - Clear s_cnt.
  - Shift rx_s into the MSB of the shift register (shreg <= {rx_s, shreg[DBIT-1:1]}).
  - If n_cnt == DBIT-1, go to STOP; otherwise increment n_cnt.
  - Otherwise each tick increments s_cnt.
- STOP: on each tick with s_cnt == SB_TICK-1:
  - Load o_dout <= shreg.
  - Load o_frame_err <= ~rx_s.
  - Pulse o_rx_done_tick.
  - Return to IDLE.
  - Otherwise each tick increments s_cnt.
- A frame with a bad stop bit is still delivered: o_dout updates, the done strobe fires, and o_frame_err = 1.
- o_dout and o_frame_err hold until the next completed frame. A glitch-aborted start leaves them unchanged.
- Ticks received in IDLE are ignored. s_cnt is only cleared on state entry.
- Line held low (break): after a frame with o_frame_err = 1 the FSM returns to IDLE. It re-enters START immediately because rx_s == 0, and keeps re-framing. No lock-up is allowed.

## Timing
- Reset values: state IDLE, s_cnt 0, n_cnt 0, shreg 0, o_dout 0, o_rx_done_tick 0, o_frame_err 0, synchronizer flops 1.
- Reset acts mid-frame: the FSM returns to IDLE asynchronously and no strobe is generated.
- Input latency: a change on i_rx is visible to the FSM 2 clocks later.
- Sampling points, measured in ticks after the start is detected in IDLE:
  - Start bit is confirmed on tick 8.
  - Data bit k is sampled on tick 8 + 16·(k+1).
  - The stop bit is sampled on tick 8 + 16·DBIT + SB_TICK.
- o_rx_done_tick is high for exactly one i_clk cycle: the cycle after the final STOP tick is registered. It is never wider than one cycle, even if i_s_tick is held high.
- o_dout and o_frame_err become valid in the same cycle o_rx_done_tick is high.
- s_cnt is 5 bits wide so that SB_TICK up to 32 fits. Comparisons are exact-equality, not wrap-dependent.

## Test plan
- Bench setup: 16x tick every 4 clocks, so one bit = 64 clocks. Send 0x55 with 1 stop bit -> one done pulse, o_dout = 0x55, o_frame_err = 0, FSM back in IDLE.
- Back-to-back frames 0xA3 then 0x0F, no idle gap -> two done pulses about 640 clocks apart, o_dout = 0xA3 then 0x0F, o_frame_err = 0 both times.
- Send 0xC4 with the stop bit forced to 0 -> done pulse, o_dout = 0xC4, o_frame_err = 1. Next good frame 0x12 -> o_frame_err returns to 0.
- Drive i_rx low for 20 clocks (5 ticks, shorter than half a bit) -> FSM returns to IDLE, no done pulse, o_dout unchanged.
- Assert i_reset = 0 in the middle of receiving data bit 4 of a frame -> all outputs are 0 immediately. After release and a clean 0x7E frame -> o_dout = 0x7E.
- With SB_TICK = 32, send 0x81 followed by 2 stop bits -> the done pulse occurs 16 ticks later than in the SB_TICK = 16 case, o_dout = 0x81.

Source files
------------

// File: rtl/uart_rx.sv
// uart_rx: 16x-oversampled serial receiver.
// Start detect, mid-bit data sampling, stop check, one-cycle done strobe.
module uart_rx #(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_rx,
  input  logic            i_s_tick,
  output logic [DBIT-1:0] o_dout,
  output logic            o_rx_done_tick,
  output logic            o_frame_err
);

  localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;

  localparam logic [4:0]    S_MID  = 5'd7;
  localparam logic [4:0]    S_END  = 5'd15;
  localparam logic [4:0]    S_STOP = 5'(SB_TICK - 1);
  localparam logic [NW-1:0] N_LAST = NW'(DBIT - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t          state_q, state_d;
  logic [4:0]      s_cnt_q, s_cnt_d;
  logic [NW-1:0]   n_cnt_q, n_cnt_d;
  logic [DBIT-1:0] shreg_q, shreg_d;
  logic [DBIT-1:0] dout_d;
  logic            ferr_d;
  logic            done_d;
  logic            rx_q;
  logic            rx_s;

  // bring the asynchronous line into the clock domain, idle high
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      rx_q <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_q <= i_rx;
      rx_s <= rx_q;
    end
  end

  // state, counters, shift register and output registers
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q        <= IDLE;
      s_cnt_q        <= '0;
      n_cnt_q        <= '0;
      shreg_q        <= '0;
      o_dout         <= '0;
      o_frame_err    <= 1'b0;
      o_rx_done_tick <= 1'b0;
    end else begin
      state_q        <= state_d;
      s_cnt_q        <= s_cnt_d;
      n_cnt_q        <= n_cnt_d;
      shreg_q        <= shreg_d;
      o_dout         <= dout_d;
      o_frame_err    <= ferr_d;
      o_rx_done_tick <= done_d;
    end
  end

  // next-state: walk start, data and stop bits on oversampling ticks
  always_comb begin
    state_d = state_q;
    s_cnt_d = s_cnt_q;
    n_cnt_d = n_cnt_q;
    shreg_d = shreg_q;
    dout_d  = o_dout;
    ferr_d  = o_frame_err;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!rx_s) begin
          state_d = START;
          s_cnt_d = '0;
        end
      end
      START: begin
        if (i_s_tick) begin
          if (s_cnt_q == S_MID) begin
            if (!rx_s) begin
              state_d = DATA;
              s_cnt_d = '0;
              n_cnt_d = '0;
            end else begin
              state_d = IDLE;
            end
          end else begin
            s_cnt_d = s_cnt_q + 5'd1;
          end
        end
      end
      DATA: begin
        if (i_s_tick) begin
          if (s_cnt_q == S_END) begin
            s_cnt_d = '0;
            shreg_d = {rx_s, shreg_q[DBIT-1:1]};
            if (n_cnt_q == N_LAST) begin
              state_d = STOP;
            end else begin
              n_cnt_d = n_cnt_q + 1'b1;
            end
          end else begin
            s_cnt_d = s_cnt_q + 5'd1;
          end
        end
      end
      STOP: begin
        if (i_s_tick) begin
          if (s_cnt_q == S_STOP) begin
            dout_d  = shreg_q;
            ferr_d  = ~rx_s;
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            s_cnt_d = s_cnt_q + 5'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: random and directed frames, scoreboard-checked.
// Two receivers: 1 stop bit and 2 stop bits.
module tb_uart_rx;

  typedef struct {
    logic [7:0] data;
    logic       ferr;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       s_tick = 1'b0;
  logic [1:0] tcnt = 2'd0;
  logic       rx16 = 1'b1;
  logic       rx32 = 1'b1;
  logic       sel16 = 1'b1;
  logic       sel32 = 1'b0;

  logic [7:0] dout16, dout32;
  logic       done16, done32;
  logic       ferr16, ferr32;

  int   n_checks = 0;
  int   n_fail = 0;
  int   cyc = 0;
  exp_t q16[$];
  exp_t q32[$];
  int   t16[$];
  int   t32[$];
  logic prev16 = 1'b0;
  logic prev32 = 1'b0;
  logic [7:0] last16 = 8'h00;

  uart_rx #(.DBIT(8), .SB_TICK(16)) dut (
    .i_clk          (clk),
    .i_reset        (rst_n),
    .i_rx           (rx16),
    .i_s_tick       (s_tick),
    .o_dout         (dout16),
    .o_rx_done_tick (done16),
    .o_frame_err    (ferr16)
  );

  uart_rx #(.DBIT(8), .SB_TICK(32)) dut32 (
    .i_clk          (clk),
    .i_reset        (rst_n),
    .i_rx           (rx32),
    .i_s_tick       (s_tick),
    .o_dout         (dout32),
    .o_rx_done_tick (done32),
    .o_frame_err    (ferr32)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc    <= cyc + 1;
    tcnt   <= tcnt + 2'd1;
    s_tick <= (tcnt == 2'd2);
  end

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // scoreboard monitor: every done strobe must match a queued frame
  always @(negedge clk) begin
    exp_t e;
    if (done16) begin
      check("done16_width", {31'd0, prev16}, 32'd0);
      t16.push_back(cyc);
      if (q16.size() == 0) begin
        check("done16_unexpected", 32'd1, 32'd0);
      end else begin
        e = q16.pop_front();
        check("dout16", {24'd0, dout16}, {24'd0, e.data});
        check("ferr16", {31'd0, ferr16}, {31'd0, e.ferr});
      end
    end
    if (done32) begin
      check("done32_width", {31'd0, prev32}, 32'd0);
      t32.push_back(cyc);
      if (q32.size() == 0) begin
        check("done32_unexpected", 32'd1, 32'd0);
      end else begin
        e = q32.pop_front();
        check("dout32", {24'd0, dout32}, {24'd0, e.data});
        check("ferr32", {31'd0, ferr32}, {31'd0, e.ferr});
      end
    end
    prev16 = done16;
    prev32 = done32;
  end

  task automatic drive(input logic v, input int n);
    if (n > 0) begin
      rx16 = sel16 ? v : 1'b1;
      rx32 = sel32 ? v : 1'b1;
      repeat (n) @(posedge clk);
      #1;
    end
  endtask

  // one frame at 64 clocks per bit; a bad stop bit is low
  // through its sample point, then the line returns high
  task automatic send_frame(input logic [7:0] d, input logic bad,
                            input int nstop);
    exp_t e;
    drive(1'b0, 64);
    for (int i = 0; i < 8; i++) drive(d[i], 64);
    e.data = d;
    e.ferr = bad;
    if (sel16) begin
      q16.push_back(e);
      last16 = d;
    end
    if (sel32) q32.push_back(e);
    if (bad) begin
      drive(1'b0, 40);
      drive(1'b1, 24);
      drive(1'b1, 64);
    end else begin
      drive(1'b1, 64 * nstop);
    end
  endtask

  task automatic check_reset_outs(input string tag);
    check({tag, "_dout"}, {24'd0, dout16}, 32'd0);
    check({tag, "_ferr"}, {31'd0, ferr16}, 32'd0);
    check({tag, "_done"}, {31'd0, done16}, 32'd0);
  endtask

  initial begin
    logic [7:0] d;
    logic       bad;
    int         diff;

    repeat (3) @(posedge clk);
    #1;
    check_reset_outs("reset");
    check("reset_dout32", {24'd0, dout32}, 32'd0);
    rst_n = 1'b1;
    drive(1'b1, 20);

    send_frame(8'h55, 1'b0, 1);
    drive(1'b1, 64);

    t16 = {};
    send_frame(8'hA3, 1'b0, 1);
    send_frame(8'h0F, 1'b0, 1);
    drive(1'b1, 100);
    check("b2b_count", t16.size(), 32'd2);
    if (t16.size() == 2) begin
      diff = t16[1] - t16[0];
      check("b2b_spacing", {31'd0, (diff >= 636 && diff <= 644)}, 32'd1);
    end

    send_frame(8'hC4, 1'b1, 1);
    send_frame(8'h12, 1'b0, 1);
    drive(1'b1, 64);

    drive(1'b0, 20);
    drive(1'b1, 200);
    check("glitch_dout", {24'd0, dout16}, {24'd0, last16});
    check("glitch_ferr", {31'd0, ferr16}, 32'd0);

    for (int k = 0; k < 10; k++) begin
      d   = 8'($urandom);
      bad = ($urandom_range(0, 3) == 0);
      send_frame(d, bad, 1);
      drive(1'b1, $urandom_range(1, 80));
    end

    send_frame(8'h3C, 1'b1, 1);
    drive(1'b1, 64);

    d = 8'h99;
    drive(1'b0, 64);
    for (int i = 0; i < 4; i++) drive(d[i], 64);
    drive(d[4], 32);
    rst_n = 1'b0;
    #1;
    check_reset_outs("midreset");
    rx16 = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive(1'b1, 64);
    send_frame(8'h7E, 1'b0, 1);
    drive(1'b1, 64);

    t16 = {};
    t32 = {};
    sel32 = 1'b1;
    send_frame(8'h81, 1'b0, 2);
    drive(1'b1, 64);
    sel32 = 1'b0;
    check("sb32_count", t32.size(), 32'd1);
    if (t16.size() == 1 && t32.size() == 1) begin
      check("sb32_delay", t32[0] - t16[0], 32'd64);
    end

    drive(1'b1, 300);
    check("q16_drained", q16.size(), 32'd0);
    check("q32_drained", q32.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
